// File: rtl/row_clear_ctrl_if.sv
// Board row RAM port: the clear sequencer drives it (master), the row store answers (slave).
interface row_clear_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ROW_W  = 16
);
  logic [ADDR_W-1:0] row_addr;
  logic              row_rd_en;
  logic [ROW_W-1:0]  row_rdata;
  logic              row_wr_en;
  logic [ROW_W-1:0]  row_wdata;

  modport master (
    output row_addr, row_rd_en, row_wr_en, row_wdata,
    input  row_rdata
  );

  modport slave (
    input  row_addr, row_rd_en, row_wr_en, row_wdata,
    output row_rdata
  );
endinterface

// File: rtl/row_clear_ctrl.sv
// Tetris line-clear sequencer: scans rows bottom to top, drops full rows,
// compacts survivors downward and zero-fills the vacated top rows.
// Optional scoring is enabled with the ROW_CLEAR_SCORE_EN macro; without it
// the score port is tied to zero.
module row_clear_ctrl #(
  parameter int unsigned BOARD_WIDTH  = 10,
  parameter int unsigned BOARD_HEIGHT = 20,
  parameter int unsigned ROW_W        = 16,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  lines_cleared,
  output logic [15:0] score,
  row_clear_ctrl_if.master ram
);

  localparam int unsigned CNT_W = 5;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(BOARD_HEIGHT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BOARD_HEIGHT);

  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, FILL, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd, rd_nxt, wr, wr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;

  logic              busy_d, done_d, rd_en_d, wr_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ROW_W-1:0]  wdata_d;
  logic [4:0]        lines_d;

  logic              row_full_c;
  assign row_full_c = &ram.row_rdata[BOARD_WIDTH-1:0];

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and pointer/counter updates
  always_comb begin
    state_nxt = state;
    rd_nxt    = rd;
    wr_nxt    = wr;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
          rd_nxt    = LAST_ROW;
          wr_nxt    = LAST_ROW;
          count_nxt = '0;
        end
      end
      READ: state_nxt = CHECK;
      CHECK: begin
        if (!row_full_c && (wr != rd)) begin
          state_nxt = WRITE;
        end else begin
          if (row_full_c) begin
            if (count != CNT_MAX) count_nxt = count + CNT_W'(1);
          end else if (wr != '0) begin
            wr_nxt = wr - ADDR_W'(1);
          end
          if (rd == '0) begin
            state_nxt = (count_nxt != '0) ? FILL : DONE;
          end else begin
            rd_nxt    = rd - ADDR_W'(1);
            state_nxt = READ;
          end
        end
      end
      WRITE: begin
        if (wr != '0) wr_nxt = wr - ADDR_W'(1);
        if (rd == '0) begin
          state_nxt = FILL;
        end else begin
          rd_nxt    = rd - ADDR_W'(1);
          state_nxt = READ;
        end
      end
      FILL: begin
        if (wr == '0) state_nxt = DONE;
        else          wr_nxt    = wr - ADDR_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming state; address/data hold when strobes drop
  always_comb begin
    busy_d  = (state_nxt != IDLE);
    done_d  = (state_nxt == DONE);
    rd_en_d = (state_nxt == READ);
    wr_en_d = (state_nxt == WRITE) || (state_nxt == FILL);
    addr_d  = ram.row_addr;
    wdata_d = ram.row_wdata;
    lines_d = lines_cleared;
    case (state_nxt)
      READ:  addr_d = rd_nxt;
      WRITE: begin
        addr_d  = wr_nxt;
        wdata_d = ram.row_rdata;
      end
      FILL: begin
        addr_d  = wr_nxt;
        wdata_d = '0;
      end
      DONE:    lines_d = count_nxt;
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd            <= LAST_ROW;
      wr            <= LAST_ROW;
      count         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram.row_rd_en <= 1'b0;
      ram.row_wr_en <= 1'b0;
      ram.row_addr  <= '0;
      ram.row_wdata <= '0;
      lines_cleared <= '0;
    end else begin
      rd            <= rd_nxt;
      wr            <= wr_nxt;
      count         <= count_nxt;
      busy          <= busy_d;
      done          <= done_d;
      ram.row_rd_en <= rd_en_d;
      ram.row_wr_en <= wr_en_d;
      ram.row_addr  <= addr_d;
      ram.row_wdata <= wdata_d;
      lines_cleared <= lines_d;
    end
  end

`ifdef ROW_CLEAR_SCORE_EN
  function automatic logic [15:0] score_inc(input logic [CNT_W-1:0] n);
    case (n)
      5'd0:    return 16'd0;
      5'd1:    return 16'd40;
      5'd2:    return 16'd100;
      5'd3:    return 16'd300;
      default: return 16'd1200;
    endcase
  endfunction

  logic [16:0] score_sum_c;
  assign score_sum_c = {1'b0, score} + {1'b0, score_inc(count_nxt)};

  // Saturating score accumulation on the DONE cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                score <= '0;
    else if (state_nxt == DONE)  score <= score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
  end
`else
  assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Bench for row_clear_ctrl: behavioural row RAM, table vectors, mid-pass reset,
// score sequence and random boards checked against a compaction model.
module tb_row_clear_ctrl;
  localparam int unsigned H      = 20;
  localparam int unsigned W      = 10;
  localparam int unsigned ROW_W  = 16;
  localparam int unsigned ADDR_W = 5;
  localparam logic [15:0] FULL_MASK = 16'h03FF;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  lines_cleared;
  logic [15:0] score;

  row_clear_ctrl_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) ram ();

  row_clear_ctrl #(
    .BOARD_WIDTH(W), .BOARD_HEIGHT(H), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .score(score), .ram(ram)
  );

  always #5 Clk = ~Clk;

  // Row RAM model with one-cycle read latency and access counters
  logic [15:0] mem [H];
  logic [15:0] cur_board [H];
  logic        load = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, ov_cnt = 0;

  always @(posedge Clk) begin
    if (load) begin
      for (int i = 0; i < H; i++) mem[i] <= cur_board[i];
    end else begin
      if (ram.row_wr_en && int'(ram.row_addr) < H) mem[ram.row_addr] <= ram.row_wdata;
      if (ram.row_rd_en) ram.row_rdata <= (int'(ram.row_addr) < H) ? mem[ram.row_addr] : 16'h0;
    end
    if (ram.row_rd_en) rd_cnt <= rd_cnt + 1;
    if (ram.row_wr_en) wr_cnt <= wr_cnt + 1;
    if (ram.row_rd_en && ram.row_wr_en) ov_cnt <= ov_cnt + 1;
  end

  int nerr = 0, nchk = 0, case_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s (case %0d): got 0x%0h, expected 0x%0h", name, case_id, act, exp);
    end
  endtask

  // Reference model: survivors keep bottom-up order, cleared rows become zero rows on top
  logic [15:0] exp_board [H];
  int m_lines, m_moved, exp_score = 0, prev_lines = 0, last_cyc = 0;

  function automatic bit is_full(input logic [15:0] w);
    return (w & FULL_MASK) == FULL_MASK;
  endfunction

  task automatic model_run();
    int k;
    bit seen;
    k = H - 1; seen = 1'b0; m_lines = 0; m_moved = 0;
    for (int r = H - 1; r >= 0; r--) begin
      if (is_full(cur_board[r])) begin
        m_lines++;
        seen = 1'b1;
      end else begin
        exp_board[k] = cur_board[r];
        k--;
        if (seen) m_moved++;
      end
    end
    for (int r = k; r >= 0; r--) exp_board[r] = 16'h0;
  endtask

  function automatic int score_next(input int s, input int l);
`ifdef ROW_CLEAR_SCORE_EN
    int inc;
    inc = (l == 0) ? 0 : (l == 1) ? 40 : (l == 2) ? 100 : (l == 3) ? 300 : 1200;
    return (s + inc > 65535) ? 65535 : s + inc;
`else
    return 0;
`endif
  endfunction

  // Stimulus tables: background fill plus sparse row overrides, with hand expectations
  typedef struct packed {
    logic [15:0] fill;
    logic [15:0] e19;
    logic [15:0] e18;
    logic [15:0] e0;
    int          exp_lines;
    int          exp_cyc;
  } vec_t;

  typedef struct packed {
    int          vid;
    int          row;
    logic [15:0] val;
  } ovr_t;

  vec_t vecs [7];
  ovr_t ovr [$];

  task automatic build_board(input int id);
    for (int r = 0; r < H; r++) cur_board[r] = vecs[id].fill;
    foreach (ovr[k]) if (ovr[k].vid == id) cur_board[ovr[k].row] = ovr[k].val;
  endtask

  task automatic rand_board();
    for (int r = 0; r < H; r++) begin
      int sel;
      logic [15:0] w;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        w = FULL_MASK | (16'($urandom) & 16'hFC00);
      end else if (sel == 1) begin
        w = 16'h0;
      end else begin
        w = 16'($urandom);
        if (is_full(w)) w[3] = 1'b0;
      end
      cur_board[r] = w;
    end
  endtask

  task automatic load_board();
    @(negedge Clk); load = 1'b1;
    @(negedge Clk); load = 1'b0;
  endtask

  task automatic reset_checks();
    chk("reset_strobes", int'({busy, done, ram.row_rd_en, ram.row_wr_en}), 0);
    chk("reset_addr", int'(ram.row_addr), 0);
    chk("reset_wdata", int'(ram.row_wdata), 0);
    chk("reset_lines", int'(lines_cleared), 0);
    chk("reset_score", int'(score), 0);
  endtask

  task automatic run_pass(input bit inject);
    int cyc;
    bit seen;
    @(negedge Clk); start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
      end
      if (inject && cyc == 5) start = 1'b1;
      if (inject && cyc == 6) start = 1'b0;
      if (cyc == 10) chk("lines_held_while_busy", int'(lines_cleared), prev_lines);
      seen = done;
    end
    last_cyc = seen ? cyc : -1;
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge Clk);
    chk("idle_after_done", int'({busy, done}), 0);
  endtask

  task automatic run_and_check(input bit inject);
    int r0, w0, o0, bad;
    model_run();
    load_board();
    r0 = rd_cnt; w0 = wr_cnt; o0 = ov_cnt;
    run_pass(inject);
    chk("lines", int'(lines_cleared), m_lines);
    chk("latency", last_cyc, 2 * H + m_moved + m_lines + 1);
    chk("reads", rd_cnt - r0, H);
    chk("writes", wr_cnt - w0, m_moved + m_lines);
    chk("rd_wr_overlap", ov_cnt - o0, 0);
    bad = 0;
    for (int r = 0; r < H; r++) if (mem[r] !== exp_board[r]) bad++;
    chk("board_rows_wrong", bad, 0);
    exp_score = score_next(exp_score, m_lines);
    chk("score", int'(score), exp_score);
    prev_lines = m_lines;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{fill:16'h0000, e19:16'h0000, e18:16'h0000, e0:16'h0, exp_lines:0,  exp_cyc:41};
    vecs[1] = '{fill:16'h0000, e19:16'h0001, e18:16'h0000, e0:16'h0, exp_lines:1,  exp_cyc:61};
    vecs[2] = '{fill:16'h0000, e19:16'h0155, e18:16'h0200, e0:16'h0, exp_lines:2,  exp_cyc:61};
    vecs[3] = '{fill:16'h0000, e19:16'h8001, e18:16'h0000, e0:16'h0, exp_lines:4,  exp_cyc:61};
    vecs[4] = '{fill:16'hFFFF, e19:16'h0000, e18:16'h0000, e0:16'h0, exp_lines:20, exp_cyc:61};
    vecs[5] = '{fill:16'h0000, e19:16'h0155, e18:16'h02AA, e0:16'h0, exp_lines:1,  exp_cyc:42};
    vecs[6] = '{fill:16'h0000, e19:16'hFC00, e18:16'h0000, e0:16'h0, exp_lines:1,  exp_cyc:61};
    ovr.push_back(ovr_t'{vid:1, row:19, val:16'h03FF});
    ovr.push_back(ovr_t'{vid:1, row:18, val:16'h0001});
    ovr.push_back(ovr_t'{vid:2, row:19, val:16'h03FF});
    ovr.push_back(ovr_t'{vid:2, row:18, val:16'h0155});
    ovr.push_back(ovr_t'{vid:2, row:17, val:16'h03FF});
    ovr.push_back(ovr_t'{vid:2, row:16, val:16'h0200});
    ovr.push_back(ovr_t'{vid:2, row:15, val:16'hFC00});
    for (int r = 16; r < 20; r++) ovr.push_back(ovr_t'{vid:3, row:r, val:16'h03FF});
    ovr.push_back(ovr_t'{vid:3, row:15, val:16'h8001});
    ovr.push_back(ovr_t'{vid:5, row:0,  val:16'h03FF});
    ovr.push_back(ovr_t'{vid:5, row:19, val:16'h0155});
    ovr.push_back(ovr_t'{vid:5, row:18, val:16'h02AA});
    ovr.push_back(ovr_t'{vid:6, row:19, val:16'hFFFF});
    ovr.push_back(ovr_t'{vid:6, row:18, val:16'hFC00});

    // Power-on reset
    repeat (3) @(negedge Clk);
    reset_checks();
    Reset_n = 1'b1;

    // Table vectors; case 2 also pulses start while busy
    for (int i = 0; i < 7; i++) begin
      case_id = i;
      build_board(i);
      run_and_check(i == 2);
      chk("hand_lines", int'(lines_cleared), vecs[i].exp_lines);
      chk("hand_latency", last_cyc, vecs[i].exp_cyc);
      chk("hand_row19", int'(mem[19]), int'(vecs[i].e19));
      chk("hand_row18", int'(mem[18]), int'(vecs[i].e18));
      chk("hand_row0", int'(mem[0]), int'(vecs[i].e0));
    end

    // Reset in the middle of a pass aborts immediately
    case_id = 100;
    build_board(1);
    load_board();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    repeat (8) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("idle_after_reset", int'(busy), 0);
    exp_score = 0;
    prev_lines = 0;

    // Two four-line passes after reset: score 1200 then 2400 when enabled
    case_id = 200;
    build_board(3);
    run_and_check(1'b0);
`ifdef ROW_CLEAR_SCORE_EN
    chk("score_first_tetris", int'(score), 1200);
`else
    chk("score_first_tetris", int'(score), 0);
`endif
    build_board(3);
    run_and_check(1'b0);
`ifdef ROW_CLEAR_SCORE_EN
    chk("score_second_tetris", int'(score), 2400);
`else
    chk("score_second_tetris", int'(score), 0);
`endif

    // Random boards against the model
    for (int n = 0; n < 12; n++) begin
      case_id = 300 + n;
      rand_board();
      run_and_check(n[0]);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
